// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. RX_IN is double-flopped into
//                rx_s. A falling edge on rx_s starts a frame. Each bit is
//                sampled at mid-period. An optional parity bit and the stop
//                bit are checked. A good frame updates P_DATA and pulses
//                data_valid for one cycle. A bad frame pulses parity_error
//                and/or stop_error and leaves P_DATA unchanged.
//  Ports       : CLK           - receiver clock, OVERSAMPLE x baud
//                RST           - synchronous active-high reset
//                RX_IN         - serial line, idle high, asynchronous
//                parity_enable - 1 = a parity bit follows the data bits
//                parity_type   - 0 = even, 1 = odd
//                P_DATA        - last good received word
//                data_valid    - one-cycle pulse when P_DATA is updated
//                parity_error  - one-cycle pulse on a parity mismatch
//                stop_error    - one-cycle pulse when the stop bit is 0
//                busy          - high while a frame is being received
//  Options     : UART_RX_MAJORITY_EN - each bit is the 2-of-3 majority of the
//                samples at edge_cnt S-1, S and S+1. Decisions move to S+1,
//                which adds one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef WIDTH
`define WIDTH 8
`endif

module uart_rx #(
    parameter int DATA_WIDTH = `WIDTH,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SAMPLE = OVERSAMPLE / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    // Every counter comparison is made on the value held before an edge.
    // "Acting at edge_cnt == N" therefore means comparing against N-1, so the
    // decision is registered on the same edge that moves edge_cnt to N.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_HIST_A = CNT_W'(SAMPLE - 2);
    localparam logic [CNT_W-1:0] CNT_HIST_B = CNT_W'(SAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(SAMPLE);
`else
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(SAMPLE - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync_q, rx_s_q;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic                    par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;

    logic                    w_decide;
    logic                    w_wrap;
    logic                    w_bit;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]              hist_q, hist_d;

    // Two earlier samples are held in hist_q; the third is the live rx_s.
    assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);

    always_comb begin
        hist_d = hist_q;
        if (edge_cnt_q == CNT_HIST_A || edge_cnt_q == CNT_HIST_B) begin
            hist_d = {hist_q[0], rx_s_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign w_bit = rx_s_q;
`endif

    assign w_decide = (edge_cnt_q == CNT_DECIDE);
    assign w_wrap   = (edge_cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = w_wrap ? '0 : edge_cnt_q + CNT_W'(1);
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
                    par_err_d  = 1'b0;
                end
            end
            ST_START: begin
                if (w_decide && w_bit) begin
                    // Line went back high before mid-bit: not a real start.
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                end else if (w_wrap) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_decide) begin
                    shift_d = {w_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (w_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_decide) begin
                    par_err_d = w_bit ^ (^shift_q) ^ par_type_q;
                end
                if (w_wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_decide) begin
                    if (w_bit && !par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    parity_error_d = par_err_q;
                    stop_error_d   = ~w_bit;
                    // Leave half a bit early so a back-to-back start is seen.
                    state_d        = ST_IDLE;
                    edge_cnt_d     = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q         <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= ST_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            sync_q         <= RX_IN;
            rx_s_q         <= sync_q;
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire
